// File: rtl/ttt2_ser_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ttt2_ser_pkg
// Purpose  : Shared constants, state encoding and helpers for the ttt2
//            response-vector serialiser.
// Revision : 1.0 - initial release
// ============================================================================
package ttt2_ser_pkg;

  // Default parallel vector width (z..t0 of the ttt2 output set)
  localparam int DEF_WIDTH = 21;
  // Default number of clock cycles per serial bit
  localparam int DEF_DIV   = 4;

  // Frame sequencer states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } ser_state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit
  function automatic int min1_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ttt2_bit_timer.sv
`default_nettype none
// ============================================================================
// Module   : ttt2_bit_timer
// Purpose  : Bit-period counter. Counts 0..DIV-1 and wraps; tick is high on
//            the last cycle of each bit period. clear holds the count at 0.
// Revision : 1.0 - initial release
// ============================================================================
module ttt2_bit_timer
  import ttt2_ser_pkg::*;
#(
  parameter int DIV = DEF_DIV
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = min1_clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_count;

  // Free-running period counter, restarted by clear and wrapping at DIV-1
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (clear || (r_count == LAST)) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  // With DIV=1 the count is pinned at 0, so every cycle ends a bit period
  assign tick = (r_count == LAST);

endmodule
`default_nettype wire

// File: rtl/ttt2_vec_ser.sv
`default_nettype none
// ============================================================================
// Module   : ttt2_vec_ser
// Purpose  : Serialises a WIDTH-bit response vector as
//            start(0) / data LSB-first / even parity / stop(1),
//            each bit held for DIV clock cycles. The line idles high.
// Revision : 1.0 - initial release
// ============================================================================
module ttt2_vec_ser
  import ttt2_ser_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIV   = DEF_DIV
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             txd,
  output logic             busy,
  output logic             frame_done
);

  localparam int            IW       = min1_clog2(WIDTH);
  localparam logic [IW-1:0] LAST_BIT = IW'(WIDTH - 1);

  ser_state_t       r_state;
  logic [WIDTH-1:0] r_shift;
  logic [IW-1:0]    r_bit_idx;
  logic             r_parity;
  logic             r_ready;
  logic             w_tick;
  logic             w_clear;

  // The timer is held in reset while idle so START always sees a full period
  assign w_clear = (r_state == IDLE);

  ttt2_bit_timer #(
    .DIV (DIV)
  ) u_bit_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (w_clear),
    .tick    (w_tick)
  );

  // Frame sequencer: captures the vector on accept and walks the frame slots
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_parity  <= 1'b0;
      r_ready   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // r_ready is low for the first cycle after reset, so no accept there
          if (din_valid && r_ready) begin
            r_shift   <= din;
            r_parity  <= ^din;
            r_bit_idx <= '0;
            r_ready   <= 1'b0;
            r_state   <= START;
          end else begin
            r_ready   <= 1'b1;
          end
        end
        START: begin
          if (w_tick) begin
            r_state <= DATA;
          end
        end
        DATA: begin
          if (w_tick) begin
            r_shift <= r_shift >> 1;
            if (r_bit_idx == LAST_BIT) begin
              r_state <= PARITY;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end
        end
        PARITY: begin
          if (w_tick) begin
            r_state <= STOP;
          end
        end
        STOP: begin
          if (w_tick) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  // Line level decoded purely from state registers (no path from din/din_valid)
  always_comb begin
    txd = 1'b1;
    case (r_state)
      START:   txd = 1'b0;
      DATA:    txd = r_shift[0];
      PARITY:  txd = r_parity;
      default: txd = 1'b1;
    endcase
  end

  assign din_ready  = r_ready;
  assign busy       = (r_state != IDLE);
  assign frame_done = (r_state == STOP) && w_tick;

endmodule
`default_nettype wire

// File: tb/tb_ttt2_vec_ser.sv
`default_nettype none
// ============================================================================
// Module   : tb_ttt2_vec_ser
// Purpose  : Self-checking bench for ttt2_vec_ser. Two instances (DIV=4 and
//            DIV=1) share clock and reset; a frame-position model predicts
//            every output each cycle, and directed literal checks pin it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ttt2_vec_ser;

  localparam int W = 21;

  logic         clock;
  logic         reset_n;
  logic [W-1:0] din4, din1;
  logic         din_valid4, din_valid1;
  logic         din_ready4, din_ready1;
  logic         txd4, txd1;
  logic         busy4, busy1;
  logic         frame_done4, frame_done1;

  int n_cmp = 0;
  int n_err = 0;
  int fc    = 0;

  ttt2_vec_ser #(.WIDTH(W), .DIV(4)) dut4 (
    .clock      (clock),
    .reset_n    (reset_n),
    .din        (din4),
    .din_valid  (din_valid4),
    .din_ready  (din_ready4),
    .txd        (txd4),
    .busy       (busy4),
    .frame_done (frame_done4)
  );

  ttt2_vec_ser #(.WIDTH(W), .DIV(1)) dut1 (
    .clock      (clock),
    .reset_n    (reset_n),
    .din        (din1),
    .din_valid  (din_valid1),
    .din_ready  (din_ready1),
    .txd        (txd1),
    .busy       (busy1),
    .frame_done (frame_done1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected line level at frame position p (1-based cycle inside the frame)
  function automatic logic exp_txd(input int p, input logic [W-1:0] vv, input int dv);
    int slot;
    if (p == 0) return 1'b1;
    slot = (p - 1) / dv;
    if (slot == 0) return 1'b0;
    if (slot <= W) return vv[slot-1];
    if (slot == W + 1) return ^vv;
    return 1'b1;
  endfunction

  // ---------------- behavioural model + per-cycle compare ----------------
  int           pos [2];
  bit           rdy [2];
  logic [W-1:0] vec [2];
  logic [W-1:0] rx  [2];
  logic         rxp [2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      pos[k] = 0; rdy[k] = 0; vec[k] = '0; rx[k] = '0; rxp[k] = 1'b0;
    end
  end

  always @(posedge clock) begin
    logic         v [2];
    logic [W-1:0] d [2];
    logic         rs;
    logic         a_txd, a_busy, a_fd, a_rdy;
    int           dv, fl, slot;
    v[0] = din_valid4; d[0] = din4;
    v[1] = din_valid1; d[1] = din1;
    rs   = reset_n;
    for (int k = 0; k < 2; k++) begin
      fl = (W + 3) * ((k == 0) ? 4 : 1);
      if (!rs) begin
        pos[k] = 0; rdy[k] = 0;
      end else if (pos[k] != 0) begin
        if (pos[k] == fl) begin pos[k] = 0; rdy[k] = 1; end
        else pos[k]++;
      end else if (rdy[k] && v[k]) begin
        vec[k] = d[k]; pos[k] = 1; rdy[k] = 0;
      end else begin
        rdy[k] = 1;
      end
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      dv     = (k == 0) ? 4 : 1;
      fl     = (W + 3) * dv;
      a_txd  = (k == 0) ? txd4        : txd1;
      a_busy = (k == 0) ? busy4       : busy1;
      a_fd   = (k == 0) ? frame_done4 : frame_done1;
      a_rdy  = (k == 0) ? din_ready4  : din_ready1;
      chk($sformatf("txd[div%0d]", dv),        32'(a_txd),  32'(exp_txd(pos[k], vec[k], dv)));
      chk($sformatf("busy[div%0d]", dv),       32'(a_busy), 32'(pos[k] != 0));
      chk($sformatf("frame_done[div%0d]", dv), 32'(a_fd),   32'(pos[k] == fl));
      chk($sformatf("din_ready[div%0d]", dv),  32'(a_rdy),  32'(rdy[k]));
      // Receiver: sample mid-bit and reassemble the vector
      if (pos[k] != 0 && ((pos[k] - 1) % dv) == dv / 2) begin
        slot = (pos[k] - 1) / dv;
        if (slot >= 1 && slot <= W) rx[k][slot-1] = a_txd;
        if (slot == W + 1) rxp[k] = a_txd;
      end
      if (pos[k] == fl) begin
        chk($sformatf("rx_vector[div%0d]", dv), 32'(rx[k]), 32'(vec[k]));
        chk($sformatf("rx_parity[div%0d]", dv), 32'(rxp[k]), 32'(^vec[k]));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Offer a vector to the DIV=4 instance; returns in frame cycle 1
  task automatic send4(input logic [W-1:0] vv);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!din_ready4 && n < 400);
    if (!din_ready4) chk("send4_timeout", 32'(0), 32'(1));
    din4       = vv;
    din_valid4 = 1'b1;
    @(posedge clock);
    #2;
    din_valid4 = 1'b0;
    fc = 1;
  endtask

  task automatic goto_cycle(input int k);
    repeat (k - fc) @(posedge clock);
    #2;
    fc = k;
  endtask

  int fd_cyc [4];
  int n_fd;

  initial begin
    reset_n    = 1'b0;
    din4       = '0;
    din1       = '0;
    din_valid4 = 1'b0;
    din_valid1 = 1'b0;

    // Reset values while reset_n is low
    repeat (2) @(posedge clock);
    #2;
    chk("rst_txd",       32'(txd4),        32'(1));
    chk("rst_busy",      32'(busy4),       32'(0));
    chk("rst_frame_done",32'(frame_done4), 32'(0));
    chk("rst_din_ready", 32'(din_ready4),  32'(0));
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #2;
    chk("ready_after_release", 32'(din_ready4), 32'(1));

    // Single-bit vector, full frame timing at DIV=4
    send4(21'h000001);
    chk("a_c1_txd",  32'(txd4), 32'(0));
    chk("a_c1_busy", 32'(busy4), 32'(1));
    chk("a_c1_rdy",  32'(din_ready4), 32'(0));
    goto_cycle(4);  chk("a_c4_txd",  32'(txd4), 32'(0));
    goto_cycle(5);  chk("a_c5_txd",  32'(txd4), 32'(1));
    goto_cycle(8);  chk("a_c8_txd",  32'(txd4), 32'(1));
    goto_cycle(9);  chk("a_c9_txd",  32'(txd4), 32'(0));
    goto_cycle(88); chk("a_c88_txd", 32'(txd4), 32'(0));
    goto_cycle(89); chk("a_c89_parity", 32'(txd4), 32'(1));
    goto_cycle(92); chk("a_c92_fd",  32'(frame_done4), 32'(0));
    goto_cycle(93); chk("a_c93_stop", 32'(txd4), 32'(1));
    goto_cycle(96); chk("a_c96_fd",  32'(frame_done4), 32'(1));
    goto_cycle(97);
    chk("a_c97_rdy",  32'(din_ready4), 32'(1));
    chk("a_c97_busy", 32'(busy4), 32'(0));
    chk("a_c97_fd",   32'(frame_done4), 32'(0));

    // Parity of all-ones and of two ones
    send4(21'h1FFFFF);
    goto_cycle(90); chk("b_ones_parity", 32'(txd4), 32'(1));
    send4(21'h000003);
    goto_cycle(90); chk("b_three_parity", 32'(txd4), 32'(0));

    // din changed mid-DATA must not affect the frame
    send4(21'h0A5A5A);
    goto_cycle(13); chk("c_bit2", 32'(txd4), 32'(0));
    goto_cycle(17); chk("c_bit3", 32'(txd4), 32'(1));
    goto_cycle(20); din4 = 21'h15A5A5;
    goto_cycle(25); chk("c_bit5_captured", 32'(txd4), 32'(0));
    goto_cycle(29); chk("c_bit6_captured", 32'(txd4), 32'(1));
    goto_cycle(97);

    // Back-to-back frames at DIV=1 with din_valid held high
    n_fd = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clock);
      din1 = W'($urandom);
      if (i == 0) din_valid1 = 1'b1;
      @(posedge clock);
      #2;
      if (frame_done1 && n_fd < 4) begin
        fd_cyc[n_fd] = i;
        n_fd++;
      end
    end
    din_valid1 = 1'b0;
    chk("d_frame_count", 32'(n_fd), 32'(3));
    chk("d_first_done",  32'(fd_cyc[0]), 32'(23));
    chk("d_spacing_1",   32'(fd_cyc[1] - fd_cyc[0]), 32'(25));
    chk("d_spacing_2",   32'(fd_cyc[2] - fd_cyc[1]), 32'(25));
    repeat (30) @(posedge clock);

    // Reset pulse in the middle of a frame
    send4(21'h012345);
    goto_cycle(40);
    din4       = 21'h1ABCDE;
    din_valid4 = 1'b1;
    reset_n    = 1'b0;
    #1;
    chk("e_abort_txd",  32'(txd4),        32'(1));
    chk("e_abort_busy", 32'(busy4),       32'(0));
    chk("e_abort_fd",   32'(frame_done4), 32'(0));
    chk("e_abort_rdy",  32'(din_ready4),  32'(0));
    @(negedge clock);
    @(negedge clock);
    din_valid4 = 1'b0;
    reset_n    = 1'b1;
    @(posedge clock);
    #2;
    chk("e_release_rdy",  32'(din_ready4),  32'(1));
    chk("e_release_busy", 32'(busy4),       32'(0));
    chk("e_release_fd",   32'(frame_done4), 32'(0));
    repeat (120) @(posedge clock);
    #2;
    chk("e_no_resume", 32'(busy4), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
